// File: rtl/xswitch_param.sv
// xswitch_param: N-port crossbar switch. Each input word is routed by address through a
// programmable table into one output FIFO. Arbitration is fixed priority or round-robin,
// and the FIFOs drain first-word-fall-through.
module xswitch_param #(
  parameter int NPORTS   = 4,
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int DEPTH    = 8,
  parameter int AE_LVL   = 1,
  parameter int AF_LVL   = DEPTH - 1,
  parameter int ARB_MODE = 0,
  localparam int PW      = $clog2(NPORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS*DW-1:0] data_in,
  input  logic [NPORTS*AW-1:0] addr_in,
  input  logic [NPORTS-1:0]    wr_en,
  output logic [NPORTS-1:0]    data_rcv,
  output logic [NPORTS-1:0]    fifo_empty,
  output logic [NPORTS-1:0]    fifo_full,
  output logic [NPORTS-1:0]    fifo_ae,
  output logic [NPORTS-1:0]    fifo_af,
  output logic [NPORTS*DW-1:0] data_out,
  output logic [NPORTS*AW-1:0] addr_out,
  input  logic [NPORTS-1:0]    rd_en,
  output logic [NPORTS-1:0]    data_rdy,
  input  logic [NPORTS*PW-1:0] prio_val,
  input  logic                 prio_wr,
  input  logic                 port_en,
  input  logic                 port_wr,
  input  logic [PW-1:0]        port_sel,
  input  logic [AW-1:0]        port_addr
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;
  localparam int WW   = AW + DW;

  logic [AW-1:0]        tbl_q     [NPORTS];
  logic [NPORTS-1:0]    en_q;
  logic [NPORTS*PW-1:0] prio_q;
  logic [PW-1:0]        rrPtr_q   [NPORTS];
  logic [WW-1:0]        mem_q     [NPORTS][DEPTH];
  logic [PTRW-1:0]      wrPtr_q   [NPORTS];
  logic [PTRW-1:0]      rdPtr_q   [NPORTS];
  logic [CW-1:0]        count_q   [NPORTS];
  logic [WW-1:0]        last_q    [NPORTS];
  logic [NPORTS-1:0]    dataRcv_q;
  logic [NPORTS-1:0]    dataRcv_d;

  logic [NPORTS-1:0]    hit;
  logic [PW-1:0]        dest      [NPORTS];
  logic [NPORTS-1:0]    grant;
  logic [PW-1:0]        winner    [NPORTS];
  logic [PW-1:0]        bestPrio  [NPORTS];
  logic [WW-1:0]        pushWord  [NPORTS];
  logic [WW-1:0]        headWord  [NPORTS];
  logic [NPORTS-1:0]    isEmpty;
  logic [NPORTS-1:0]    isFull;
  logic [NPORTS-1:0]    doPop;

  // Address table and priority register; out-of-range table selects are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < NPORTS; j++) tbl_q[j] <= AW'(j);
      en_q   <= '1;
      prio_q <= '0;
    end else begin
      if (prio_wr) prio_q <= prio_val;
      if (port_wr && (int'(port_sel) < NPORTS)) begin
        tbl_q[port_sel] <= port_addr;
        en_q[port_sel]  <= port_en;
      end
    end
  end

  // FIFO status derived purely from the registered occupancy count
  always_comb begin
    for (int j = 0; j < NPORTS; j++) begin
      isEmpty[j] = (count_q[j] == '0);
      isFull[j]  = (count_q[j] == CW'(DEPTH));
      doPop[j]   = rd_en[j] && !isEmpty[j];
      fifo_ae[j] = (int'(count_q[j]) <= AE_LVL);
      fifo_af[j] = (int'(count_q[j]) >= AF_LVL);
    end
    fifo_empty = isEmpty;
    fifo_full  = isFull;
    data_rdy   = ~isEmpty;
  end

  // Route each input to the lowest enabled table entry whose address matches
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      hit[i]  = 1'b0;
      dest[i] = '0;
      for (int j = NPORTS - 1; j >= 0; j--) begin
        if (en_q[j] && (tbl_q[j] == addr_in[i*AW +: AW])) begin
          hit[i]  = 1'b1;
          dest[i] = PW'(j);
        end
      end
    end
  end

  // Per-output arbitration; round-robin scans from rrPtr, fixed mode keeps the first highest priority
  always_comb begin : arbComb
    int idx;
    idx = 0;
    for (int j = 0; j < NPORTS; j++) begin
      grant[j]    = 1'b0;
      winner[j]   = '0;
      bestPrio[j] = '0;
      for (int k = 0; k < NPORTS; k++) begin
        idx = (ARB_MODE == 1) ? int'(rrPtr_q[j]) + k : k;
        if (idx >= NPORTS) idx = idx - NPORTS;
        if (wr_en[idx] && hit[idx] && (dest[idx] == PW'(j)) && !isFull[j]) begin
          if (ARB_MODE == 1) begin
            if (!grant[j]) begin
              grant[j]  = 1'b1;
              winner[j] = PW'(idx);
            end
          end else if (!grant[j] || (prio_q[idx*PW +: PW] > bestPrio[j])) begin
            grant[j]    = 1'b1;
            winner[j]   = PW'(idx);
            bestPrio[j] = prio_q[idx*PW +: PW];
          end
        end
      end
      pushWord[j] = {addr_in[winner[j]*AW +: AW], data_in[winner[j]*DW +: DW]};
    end
  end

  // Collect which inputs were granted this cycle so they see an accept pulse next cycle
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      dataRcv_d[i] = 1'b0;
      for (int j = 0; j < NPORTS; j++) begin
        if (grant[j] && (winner[j] == PW'(i))) dataRcv_d[i] = 1'b1;
      end
    end
  end

  // FIFO storage array, written only by a granted push
  always_ff @(posedge clk) begin
    for (int j = 0; j < NPORTS; j++) begin
      if (grant[j]) mem_q[j][wrPtr_q[j]] <= pushWord[j];
    end
  end

  // FIFO pointers, counts, held output word, round-robin pointers and accept pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < NPORTS; j++) begin
        wrPtr_q[j] <= '0;
        rdPtr_q[j] <= '0;
        count_q[j] <= '0;
        last_q[j]  <= '0;
        rrPtr_q[j] <= '0;
      end
      dataRcv_q <= '0;
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        if (grant[j]) wrPtr_q[j] <= wrPtr_q[j] + PTRW'(1);
        if (doPop[j]) rdPtr_q[j] <= rdPtr_q[j] + PTRW'(1);
        if (grant[j] && !doPop[j]) count_q[j] <= count_q[j] + CW'(1);
        else if (!grant[j] && doPop[j]) count_q[j] <= count_q[j] - CW'(1);
        if (!isEmpty[j]) last_q[j] <= mem_q[j][rdPtr_q[j]];
        if (grant[j]) begin
          rrPtr_q[j] <= (int'(winner[j]) == NPORTS - 1) ? '0 : winner[j] + PW'(1);
        end
      end
      dataRcv_q <= dataRcv_d;
    end
  end

  // Head-of-FIFO view, falling back to the last shown word when the FIFO is empty
  always_comb begin
    data_rcv = dataRcv_q;
    data_out = '0;
    addr_out = '0;
    for (int j = 0; j < NPORTS; j++) begin
      headWord[j] = isEmpty[j] ? last_q[j] : mem_q[j][rdPtr_q[j]];
      data_out[j*DW +: DW] = headWord[j][DW-1:0];
      addr_out[j*AW +: AW] = headWord[j][WW-1 -: AW];
    end
  end

endmodule

// File: tb/tb_xswitch_param.sv
// tb_xswitch_param: directed checks of the crossbar in fixed-priority (dut0) and
// round-robin (dut1) configurations; both instances share all inputs.
module tb_xswitch_param;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*DW-1:0] data_in;
  logic [N*AW-1:0] addr_in;
  logic [N-1:0]    wr_en;
  logic [N-1:0]    rd_en;
  logic [N*PW-1:0] prio_val;
  logic            prio_wr;
  logic            port_en;
  logic            port_wr;
  logic [PW-1:0]   port_sel;
  logic [AW-1:0]   port_addr;

  logic [N-1:0]    dataRcv0, empty0, full0, ae0, af0, dataRdy0;
  logic [N*DW-1:0] dataOut0;
  logic [N*AW-1:0] addrOut0;
  logic [N-1:0]    dataRcv1, empty1, full1, ae1, af1, dataRdy1;
  logic [N*DW-1:0] dataOut1;
  logic [N*AW-1:0] addrOut1;

  int testsRun  = 0;
  int failCount = 0;

  xswitch_param #(.NPORTS(N), .DW(DW), .AW(AW), .DEPTH(8), .ARB_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .data_in(data_in), .addr_in(addr_in), .wr_en(wr_en),
    .data_rcv(dataRcv0), .fifo_empty(empty0), .fifo_full(full0), .fifo_ae(ae0),
    .fifo_af(af0), .data_out(dataOut0), .addr_out(addrOut0), .rd_en(rd_en),
    .data_rdy(dataRdy0), .prio_val(prio_val), .prio_wr(prio_wr), .port_en(port_en),
    .port_wr(port_wr), .port_sel(port_sel), .port_addr(port_addr)
  );

  xswitch_param #(.NPORTS(N), .DW(DW), .AW(AW), .DEPTH(8), .ARB_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .addr_in(addr_in), .wr_en(wr_en),
    .data_rcv(dataRcv1), .fifo_empty(empty1), .fifo_full(full1), .fifo_ae(ae1),
    .fifo_af(af1), .data_out(dataOut1), .addr_out(addrOut1), .rd_en(rd_en),
    .data_rdy(dataRdy1), .prio_val(prio_val), .prio_wr(prio_wr), .port_en(port_en),
    .port_wr(port_wr), .port_sel(port_sel), .port_addr(port_addr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  // Place one {addr,data} word on input port p
  task automatic applyStimulus(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr_in[p*AW +: AW] = a;
    data_in[p*DW +: DW] = d;
  endtask

  // Quiet all inputs and pulse reset low for two cycles
  task automatic applyReset();
    data_in = '0; addr_in = '0; wr_en = '0; rd_en = '0;
    prio_val = '0; prio_wr = 1'b0; port_en = 1'b0; port_wr = 1'b0;
    port_sel = '0; port_addr = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    applyReset();

    // Reset defaults, then a single word from in0 to out2 and its read-out
    checkOutput("rst data_rcv", 64'(dataRcv0), 64'h0);
    checkOutput("rst empty", 64'(empty0), 64'hF);
    checkOutput("rst full", 64'(full0), 64'h0);
    checkOutput("rst ae", 64'(ae0), 64'hF);
    checkOutput("rst af", 64'(af0), 64'h0);
    checkOutput("rst data_rdy", 64'(dataRdy0), 64'h0);
    checkOutput("rst data_out", 64'(dataOut0), 64'h0);
    checkOutput("rst addr_out", 64'(addrOut0), 64'h0);
    checkOutput("rst rr empty", 64'(empty1), 64'hF);
    applyStimulus(0, 16'h0002, 16'hA5A5);
    wr_en = 4'b0001;
    tick();
    wr_en = '0;
    checkOutput("t1 data_rcv", 64'(dataRcv0), 64'h1);
    checkOutput("t1 data_rdy", 64'(dataRdy0), 64'h4);
    checkOutput("t1 data_out", 64'(dataOut0[47:32]), 64'hA5A5);
    checkOutput("t1 addr_out", 64'(addrOut0[47:32]), 64'h2);
    rd_en = 4'b0100;
    tick();
    checkOutput("t1 empty after pop", 64'(empty0), 64'hF);
    checkOutput("t1 rcv pulse ended", 64'(dataRcv0), 64'h0);
    checkOutput("t1 data_out held", 64'(dataOut0[47:32]), 64'hA5A5);
    tick();
    rd_en = '0;
    checkOutput("t1 pop on empty", 64'(ae0), 64'hF);
    applyStimulus(0, 16'h0002, 16'hBEEF);
    wr_en = 4'b0001;
    tick();
    wr_en = '0;
    checkOutput("t1 rdy after underflow try", 64'(dataRdy0), 64'h4);
    rd_en = 4'b0100;
    tick();
    rd_en = '0;
    checkOutput("t1 single pop empties", 64'(empty0), 64'hF);

    // Fixed priority: in1 (prio 3) beats in3 (prio 1) for out0
    applyReset();
    prio_val = 8'h4C;
    prio_wr = 1'b1;
    tick();
    prio_wr = 1'b0;
    applyStimulus(1, 16'h0000, 16'h1111);
    applyStimulus(3, 16'h0000, 16'h3333);
    wr_en = 4'b1010;
    tick();
    checkOutput("t2 first grant", 64'(dataRcv0), 64'h2);
    wr_en = 4'b1000;
    tick();
    wr_en = '0;
    checkOutput("t2 second grant", 64'(dataRcv0), 64'h8);
    checkOutput("t2 head in1", 64'(dataOut0[15:0]), 64'h1111);
    rd_en = 4'b0001;
    tick();
    rd_en = '0;
    checkOutput("t2 next in3", 64'(dataOut0[15:0]), 64'h3333);

    // Round-robin: four inputs contend for out1 continuously
    applyReset();
    for (int i = 0; i < N; i++) applyStimulus(i, 16'h0001, 16'(16'h3000 + i));
    wr_en = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("t3 rr grant %0d", k), 64'(dataRcv1), 64'(4'b0001 << (k % 4)));
    end
    wr_en = '0;
    checkOutput("t3 out1 full", 64'(full1[1]), 64'h1);
    checkOutput("t3 head 0", 64'(dataOut1[31:16]), 64'h3000);
    rd_en = 4'b0010;
    tick();
    rd_en = '0;
    checkOutput("t3 head 1", 64'(dataOut1[31:16]), 64'h3001);

    // Fill out0 to its limit, block the ninth word, then pop-while-full and refill
    applyReset();
    wr_en = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 16'h0000, 16'(16'h4000 + k));
      tick();
      checkOutput($sformatf("t4 accept %0d", k), 64'(dataRcv0[0]), 64'h1);
      if (k == 5) checkOutput("t4 af below level", 64'(af0[0]), 64'h0);
      if (k == 6) checkOutput("t4 af at 7", 64'(af0[0]), 64'h1);
      if (k == 6) checkOutput("t4 not full at 7", 64'(full0[0]), 64'h0);
      if (k == 7) checkOutput("t4 full at 8", 64'(full0[0]), 64'h1);
    end
    applyStimulus(0, 16'h0000, 16'h4008);
    tick();
    checkOutput("t4 ninth blocked", 64'(dataRcv0[0]), 64'h0);
    rd_en = 4'b0001;
    tick();
    rd_en = '0;
    checkOutput("t4 pop-only rcv", 64'(dataRcv0[0]), 64'h0);
    checkOutput("t4 pop-only not full", 64'(full0[0]), 64'h0);
    checkOutput("t4 pop-only af", 64'(af0[0]), 64'h1);
    checkOutput("t4 head after pop", 64'(dataOut0[15:0]), 64'h4001);
    tick();
    wr_en = '0;
    checkOutput("t4 refill accepted", 64'(dataRcv0[0]), 64'h1);
    checkOutput("t4 refill full", 64'(full0[0]), 64'h1);

    // Table reprogramming: 0x0040 goes to out3, disabled entry 1 never accepts
    applyReset();
    port_wr = 1'b1; port_sel = 2'd3; port_addr = 16'h0040; port_en = 1'b1;
    tick();
    port_sel = 2'd1; port_addr = 16'h0001; port_en = 1'b0;
    tick();
    port_wr = 1'b0;
    applyStimulus(0, 16'h0040, 16'h5555);
    applyStimulus(2, 16'h0001, 16'h6666);
    wr_en = 4'b0101;
    tick();
    wr_en = 4'b0100;
    checkOutput("t5 accept 0x40", 64'(dataRcv0), 64'h1);
    checkOutput("t5 routed to out3", 64'(dataRdy0), 64'h8);
    checkOutput("t5 out3 data", 64'(dataOut0[63:48]), 64'h5555);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("t5 disabled never %0d", k), 64'(dataRcv0[2]), 64'h0);
    end
    wr_en = '0;

    // Asynchronous reset with five words queued in out2
    applyReset();
    applyStimulus(0, 16'h0002, 16'h7777);
    wr_en = 4'b0001;
    for (int k = 0; k < 5; k++) tick();
    wr_en = '0;
    checkOutput("t6 queued", 64'(dataRdy0), 64'h4);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6 async empty", 64'(empty0), 64'hF);
    checkOutput("t6 async rdy", 64'(dataRdy0), 64'h0);
    checkOutput("t6 async rcv", 64'(dataRcv0), 64'h0);
    checkOutput("t6 async ae", 64'(ae0), 64'hF);
    checkOutput("t6 async data_out", 64'(dataOut0), 64'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("t6 no rdy after release", 64'(dataRdy0), 64'h0);
    checkOutput("t6 empty after release", 64'(empty0), 64'hF);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
